shift_mix: RTL and testbench
============================

// Module: shift_mix
// PURPOSE
// - Round stage directly downstream of SubBytes: takes the 16 substituted bytes, applies ShiftRows, then MixColumns.
// - Computes MixColumns one column per clock and hands the 16 result bytes to AddRoundKey.
// - Final round bypasses MixColumns, giving ShiftRows only.
// PARAMETERS
// - BYPASS_LAST  1  1: last_round=1 skips MixColumns; 0: last_round ignored, MixColumns always applied
// - DONE_HOLD    0  0: done is a one-cycle pulse; 1: done held high until next accepted en or rst
// PORTS
// - clk         input   1  clock, rising edge
// - rst         input   1  synchronous reset, active-high
// - en          input   1  start request; sampled only in IDLE (driven by SubBytes done)
// - last_round  input   1  final AES round flag; sampled with en
// - s0..s15     input   8 each  state bytes from SubBytes, column-major (s[4c+r] = row r, col c)
// - m0..m15     output  8 each  result bytes to AddRoundKey, column-major
// - busy        output  1  high from the cycle after en accepted until done asserts
// - done        output  1  result valid on m0..m15
// BEHAVIOUR
// - Single clock domain (clk); reset is synchronous, active-high (rst).
// - Reset: state=IDLE; m0..m15=8'h00; busy=0; done=0; latched last_round=0. Reset mid-operation aborts; no done is produced.
// - States: IDLE -> COL0 -> COL1 -> COL2 -> COL3 -> IDLE.
// - Edge E0, IDLE with en=1:
//   - latch t[4c+r] = s[4((c+r)%4)+r] (ShiftRows: row r rotated left by r), i.e. t0..t15 = s0,s5,s10,s15, s4,s9,s14,s3, s8,s13,s2,s7, s12,s1,s6,s11
//   - latch last_round; busy<=1; clear done; go to COL0.
// - Edges E1..E4 (COLk): write m[4k..4k+3] from column k of t; other m bytes hold.
// - Edge E4 also sets done<=1, busy<=0, state IDLE.
// - Timing: done is visible in the cycle after E4, 5 clocks after en is sampled; latency is fixed, bypass included.
// - MixColumns on column (a0,a1,a2,a3), GF(2^8):
//   - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00); 3a = xtime(a)^a
//   - o0=2a0^3a1^a2^a3; o1=a0^2a1^3a2^a3; o2=a0^a1^2a2^3a3; o3=3a0^a1^a2^2a3
// - Bypass (BYPASS_LAST=1 and latched last_round=1): o_r = a_r.
// - en while busy: ignored; s inputs are not resampled. Inputs are only sampled at E0.
// - en high in the cycle done is high (state IDLE): accepted as a new start.
//   - DONE_HOLD=0: done drops after one cycle regardless.
//   - DONE_HOLD=1: done clears on that acceptance.
// - m0..m15 hold their last values in IDLE. During a new operation they update column by column; consumers read only when done=1.
// - en held high continuously: back-to-back operations, one every 5 clocks.
// CONFIGURATION
// - SHIFT_MIX_ERR_EN defined:
//   - adds output err (1 bit), sticky, reset to 0
//   - set on any clock with en=1 while busy=1 (overrun from SubBytes); cleared only by rst
//   - no effect on datapath or timing
// - SHIFT_MIX_ERR_EN undefined: port err absent; overrun en silently ignored.
// TESTING
// - FIPS-197 App.B round 1, last_round=0: s0..s15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30
//   -> done after 5 clks, m = 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c.
// - Same input, last_round=1 -> m = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, same 5-clk latency.
// - Column vectors (set so post-shift column 0 = db 13 53 45) -> m0..m3 = 8e 4d a1 bc.
//   Also check c6 c6 c6 c6 -> unchanged; d4 d4 d4 d5 -> d5 d5 d7 d6.
// - en pulsed again at clk 2 of an operation (inputs changed) -> result unchanged from first inputs;
//   with SHIFT_MIX_ERR_EN, err=1 and stays 1 until rst.
// - rst asserted at COL2 -> next cycle m0..m15=00, busy=0, done=0; a following en gives a correct result 5 clks later.
// - en held high for 3 operations -> done every 5 clks, each m matches its vector;
//   DONE_HOLD=1 -> done high from first completion until each re-acceptance.

Source files
------------

// File: rtl/shift_mix.sv
// AES round stage after SubBytes: ShiftRows on the latched input, then MixColumns one column per clock.
// Optional sticky overrun flag `err` is built when SHIFT_MIX_ERR_EN is defined.
module shift_mix #(
    parameter int BYPASS_LAST = 1,
    parameter int DONE_HOLD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       last_round,
    input  logic [7:0] s0,  input  logic [7:0] s1,  input  logic [7:0] s2,  input  logic [7:0] s3,
    input  logic [7:0] s4,  input  logic [7:0] s5,  input  logic [7:0] s6,  input  logic [7:0] s7,
    input  logic [7:0] s8,  input  logic [7:0] s9,  input  logic [7:0] s10, input  logic [7:0] s11,
    input  logic [7:0] s12, input  logic [7:0] s13, input  logic [7:0] s14, input  logic [7:0] s15,
    output logic [7:0] m0,  output logic [7:0] m1,  output logic [7:0] m2,  output logic [7:0] m3,
    output logic [7:0] m4,  output logic [7:0] m5,  output logic [7:0] m6,  output logic [7:0] m7,
    output logic [7:0] m8,  output logic [7:0] m9,  output logic [7:0] m10, output logic [7:0] m11,
    output logic [7:0] m12, output logic [7:0] m13, output logic [7:0] m14, output logic [7:0] m15,
    output logic       busy,
    output logic       done
`ifdef SHIFT_MIX_ERR_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [2:0] {IDLE, COL0, COL1, COL2, COL3} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // [column][row] view of the column-major byte order
    logic [3:0][3:0][7:0] s_in, t_sh, t_q, m_q;
    logic [3:0][7:0]      a, o;
    logic                 last_q;
    state_t               state_q, state_d;
    logic                 accept, col_we, last_col;
    logic [1:0]           col_idx;

    assign s_in = {s15, s14, s13, s12, s11, s10, s9, s8, s7, s6, s5, s4, s3, s2, s1, s0};
    assign {m15, m14, m13, m12, m11, m10, m9, m8, m7, m6, m5, m4, m3, m2, m1, m0} = m_q;

    // ShiftRows: row r of column c comes from column (c+r)%4
    always_comb begin
        t_sh = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t_sh[c][r] = s_in[(c + r) % 4][r];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = COL0;
            COL0:    state_d = COL1;
            COL1:    state_d = COL2;
            COL2:    state_d = COL3;
            COL3:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        col_we   = 1'b0;
        col_idx  = 2'd0;
        last_col = 1'b0;
        case (state_q)
            IDLE:    accept = en;
            COL0:    begin col_we = 1'b1; col_idx = 2'd0; end
            COL1:    begin col_we = 1'b1; col_idx = 2'd1; end
            COL2:    begin col_we = 1'b1; col_idx = 2'd2; end
            COL3:    begin col_we = 1'b1; col_idx = 2'd3; last_col = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        a = t_q[col_idx];
        if (BYPASS_LAST != 0 && last_q) begin
            o = a;
        end else begin
            o[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
            o[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
            o[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
            o[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q    <= '0;
            m_q    <= '0;
            last_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (accept) begin
                t_q    <= t_sh;
                last_q <= last_round;
                busy   <= 1'b1;
                done   <= 1'b0;
            end else if (last_col) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else if (DONE_HOLD == 0) begin
                done <= 1'b0;
            end
            if (col_we) m_q[col_idx] <= o;
        end
    end

`ifdef SHIFT_MIX_ERR_EN
    // Overrun from SubBytes: a start request arrived while a column pass was in flight
    always_ff @(posedge clk) begin
        if (rst)              err <= 1'b0;
        else if (en && busy)  err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_shift_mix.sv
// Directed + randomized bench for shift_mix; reference is a plain GF(2^8) matrix model.
module tb_shift_mix;
    typedef logic [15:0][7:0] blk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, last_round, busy, done;
    blk_t sv, mo;
    logic [7:0] m0, m1, m2, m3, m4, m5, m6, m7, m8, m9, m10, m11, m12, m13, m14, m15;
`ifdef SHIFT_MIX_ERR_EN
    logic err;
`endif
    int ncmp = 0, nfail = 0;

    assign mo = {m15, m14, m13, m12, m11, m10, m9, m8, m7, m6, m5, m4, m3, m2, m1, m0};

    shift_mix dut (
        .clk(clk), .rst(rst), .en(en), .last_round(last_round),
        .s0(sv[0]), .s1(sv[1]), .s2(sv[2]), .s3(sv[3]), .s4(sv[4]), .s5(sv[5]), .s6(sv[6]), .s7(sv[7]),
        .s8(sv[8]), .s9(sv[9]), .s10(sv[10]), .s11(sv[11]), .s12(sv[12]), .s13(sv[13]), .s14(sv[14]), .s15(sv[15]),
        .m0(m0), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5), .m6(m6), .m7(m7),
        .m8(m8), .m9(m9), .m10(m10), .m11(m11), .m12(m12), .m13(m13), .m14(m14), .m15(m15),
        .busy(busy), .done(done)
`ifdef SHIFT_MIX_ERR_EN
        , .err(err)
`endif
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // AES round fragment from first principles: rotate rows, then multiply by the circulant (2 3 1 1)
    function automatic blk_t ref_op(input blk_t s, input bit lr);
        blk_t t, r;
        logic [7:0] acc, cf;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                t[4*c + w] = s[4*((c + w) % 4) + w];
        if (lr) return t;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    cf = ((j - w + 4) % 4 == 0) ? 8'h02 : ((j - w + 4) % 4 == 1) ? 8'h03 : 8'h01;
                    acc ^= gf_mul(cf, t[4*c + j]);
                end
                r[4*c + w] = acc;
            end
        return r;
    endfunction

    function automatic blk_t rand_blk();
        blk_t v;
        for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input blk_t v, input bit lr);
        sv = v;
        last_round = lr;
        en = 1'b1;
    endtask

    // Count negedges until done; a missing done shows up as a latency of 12
    task automatic wait_done(input string tag, input bit hold_en, input int expk);
        int k = 0;
        while (k < 12) begin
            @(negedge clk);
            k++;
            if (!hold_en) en = 1'b0;
            if (done) break;
        end
        chk({tag, "_latency"}, 128'(k), 128'(expk));
    endtask

    initial begin
        blk_t fips, v0, v1, exp_m;
        blk_t bb [3];
        bit   bl [3];
        logic [3:0][7:0] cols [3];
        logic [3:0][7:0] cexp [3];
        bit lr;

        fips = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;
        rst = 1'b1; en = 1'b0; last_round = 1'b0; sv = '0;
        repeat (3) @(negedge clk);
        chk("reset_m", mo, 128'h0);
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
`ifdef SHIFT_MIX_ERR_EN
        chk("reset_err", 128'(err), 128'(0));
`endif
        rst = 1'b0;
        @(negedge clk);

        start(fips, 1'b0);
        @(negedge clk);
        en = 1'b0;
        chk("fips_busy_early", 128'(busy), 128'(1));
        wait_done("fips", 1'b0, 4);
        chk("fips_m", mo, 128'h4c_26_06_28_7a_d3_f8_48_9a_19_cb_e0_e5_81_66_04);
        chk("fips_model", mo, ref_op(fips, 1'b0));
        chk("fips_busy_at_done", 128'(busy), 128'(0));
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'(0));

        start(fips, 1'b1);
        wait_done("fips_last", 1'b0, 5);
        chk("fips_last_m", mo, 128'he5_98_27_1e_f1_11_41_b8_ae_52_b4_e0_30_5d_bf_d4);

        cols[0] = 32'h45_53_13_db; cexp[0] = 32'hbc_a1_4d_8e;
        cols[1] = 32'hc6_c6_c6_c6; cexp[1] = 32'hc6_c6_c6_c6;
        cols[2] = 32'hd5_d4_d4_d4; cexp[2] = 32'hd6_d7_d5_d5;
        for (int i = 0; i < 3; i++) begin
            v0 = rand_blk();
            v0[0] = cols[i][0]; v0[5] = cols[i][1]; v0[10] = cols[i][2]; v0[15] = cols[i][3];
            start(v0, 1'b0);
            wait_done("col", 1'b0, 5);
            chk($sformatf("col%0d_m0_3", i), 128'({m3, m2, m1, m0}), 128'(cexp[i]));
            chk($sformatf("col%0d_model", i), mo, ref_op(v0, 1'b0));
        end

        // Second en during an operation must not disturb the running one
        v0 = rand_blk(); v1 = rand_blk();
        start(v0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        start(v1, 1'b1);
        @(negedge clk);
        en = 1'b0;
        wait_done("overrun", 1'b0, 2);
        chk("overrun_m", mo, ref_op(v0, 1'b0));
`ifdef SHIFT_MIX_ERR_EN
        chk("overrun_err", 128'(err), 128'(1));
        repeat (2) @(negedge clk);
        chk("err_sticky", 128'(err), 128'(1));
`endif

        // Reset during COL2 aborts the operation
        start(rand_blk(), 1'b0);
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m", mo, 128'h0);
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
`ifdef SHIFT_MIX_ERR_EN
        chk("midrst_err", 128'(err), 128'(0));
`endif
        rst = 1'b0;
        v0 = rand_blk();
        lr = 1'($urandom);
        start(v0, lr);
        wait_done("after_rst", 1'b0, 5);
        chk("after_rst_m", mo, ref_op(v0, lr));

        // en held high: one result every 5 clocks
        for (int i = 0; i < 3; i++) begin
            bb[i] = rand_blk();
            bl[i] = 1'($urandom);
        end
        start(bb[0], bl[0]);
        for (int i = 0; i < 3; i++) begin
            wait_done($sformatf("b2b%0d", i), 1'b1, 5);
            chk($sformatf("b2b%0d_m", i), mo, ref_op(bb[i], bl[i]));
            if (i < 2) begin
                sv = bb[i+1];
                last_round = bl[i+1];
            end
        end
        en = 1'b0;

        for (int i = 0; i < 15; i++) begin
            v0 = rand_blk();
            lr = 1'($urandom);
            start(v0, lr);
            wait_done("rand", 1'b0, 5);
            exp_m = ref_op(v0, lr);
            chk($sformatf("rand%0d_m", i), mo, exp_m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
